// File: rtl/send_buff.sv
// send_buff: transmit-side FIFO that drains {data, tag, dest} entries in strict
// push order onto an outbound valid/ready link, gated by link-level credits that
// mirror free slots in the downstream receive buffer.
module send_buff #(
    parameter int NUM_ENTRY   = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int TAG_WIDTH   = 16,
    parameter int DEST_WIDTH  = 6,
    parameter int CREDIT_INIT = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wen,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic [TAG_WIDTH-1:0]             tag_in,
    input  logic [DEST_WIDTH-1:0]            dest_in,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(NUM_ENTRY):0]       count,
    output logic                             overflow,
    output logic                             tx_valid,
    input  logic                             tx_ready,
    output logic [DATA_WIDTH-1:0]            tx_data,
    output logic [TAG_WIDTH-1:0]             tx_tag,
    output logic [DEST_WIDTH-1:0]            tx_dest,
    input  logic                             credit_ret,
    output logic [$clog2(CREDIT_INIT):0]     credits
);

    localparam int AW = $clog2(NUM_ENTRY);
    localparam int CW = AW + 1;
    localparam int KW = $clog2(CREDIT_INIT) + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DEST_WIDTH-1:0] dest;
    } entry_t;

    entry_t        mem [NUM_ENTRY];
    entry_t        head_entry;

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [KW-1:0] credits_q, credits_d;
    logic          overflow_q, overflow_d;

    logic          push;
    logic          xfer;

    // Status and handshake are combinational from the registered state only,
    // so tx_valid never depends on tx_ready.
    always_comb begin
        full       = (count_q == CW'(NUM_ENTRY));
        empty      = (count_q == '0);
        tx_valid   = !empty && (credits_q != '0);
        push       = wen && !full;
        xfer       = tx_valid && tx_ready;
        head_entry = mem[head_q];
        tx_data    = head_entry.data;
        tx_tag     = head_entry.tag;
        tx_dest    = head_entry.dest;
        count      = count_q;
        credits    = credits_q;
        overflow   = overflow_q;
    end

    // Entry storage: written at tail on an accepted push, never cleared.
    // The head is read without a register stage so the link sees it at once.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_q] <= '{data: data_in, tag: tag_in, dest: dest_in};
        end
    end

    // Next-state for pointers, occupancy, credits and the sticky overflow flag.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        credits_d  = credits_q;
        overflow_d = overflow_q;

        if (push) begin
            tail_d = tail_q + AW'(1);
        end
        if (xfer) begin
            head_d = head_q + AW'(1);
        end
        if (wen && full) begin
            overflow_d = 1'b1;
        end

        unique case ({push, xfer})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A return arriving while already at the initial credit count is a
        // protocol error upstream; it is absorbed so credits never exceed it.
        unique case ({xfer, credit_ret})
            2'b10:   credits_d = credits_q - KW'(1);
            2'b01:   credits_d = (credits_q == KW'(CREDIT_INIT)) ? credits_q
                                                                  : credits_q + KW'(1);
            default: credits_d = credits_q;
        endcase
    end

    // State register with synchronous reset; storage contents are left alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            credits_q  <= KW'(CREDIT_INIT);
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            credits_q  <= credits_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: doc/send_buff.md
Name: send_buff

Overview:
- Transmit-side counterpart of the tile receive buffer.
- The tile core pushes (data, tag, destination) entries.
- The buffer drains them in strict FIFO order onto the outbound NoC link using a valid/ready handshake.
- Each launch is gated by link-level credits that mirror free entries in the downstream receive buffer; credits come back one per consumed entry.

Parameters:
- NUM_ENTRY, 8, FIFO depth; power of two, at least 2.
- DATA_WIDTH, 16, payload bits per entry.
- TAG_WIDTH, 16, tag bits; matched downstream by the receive buffer.
- DEST_WIDTH, 6, destination tile id bits.
- CREDIT_INIT, 8, credits loaded at reset; equals downstream receive buffer depth.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wen  input  1  push request from the tile.
- data_in  input  DATA_WIDTH  push payload.
- tag_in  input  TAG_WIDTH  push tag.
- dest_in  input  DEST_WIDTH  push destination tile.
- full  output  1  no free entry.
- empty  output  1  no valid entry.
- count  output  $clog2(NUM_ENTRY)+1  number of valid entries.
- overflow  output  1  sticky: a push was attempted while full.
- tx_valid  output  1  head entry offered to the link.
- tx_ready  input  1  link accepts the head this cycle.
- tx_data  output  DATA_WIDTH  head payload.
- tx_tag  output  TAG_WIDTH  head tag.
- tx_dest  output  DEST_WIDTH  head destination.
- credit_ret  input  1  one credit returned this cycle.
- credits  output  $clog2(CREDIT_INIT)+1  available credits.

Behaviour:
- Reset (rst high at posedge):
  - head pointer, tail pointer and count = 0.
  - credits = CREDIT_INIT; overflow = 0.
  - Resulting outputs: empty=1, full=0, tx_valid=0.
  - Entry storage is not cleared.
  - Reset mid-transfer discards all entries; no partial transfer exists because the handshake is single-cycle.
- Storage: circular FIFO, NUM_ENTRY entries of {data, tag, dest}. Head and tail are log2(NUM_ENTRY)-bit pointers that wrap from NUM_ENTRY-1 to 0.
- Status flags: full = (count==NUM_ENTRY); empty = (count==0). Both are combinational from count.
- Push:
  - Accepted when wen && !full: the entry is written at tail, tail increments, and the entry is visible at head the next cycle at the earliest.
  - When wen && full: input is dropped, overflow is set, and no state changes.
- Send handshake:
  - tx_valid = !empty && (credits != 0), combinational.
  - tx_data, tx_tag and tx_dest are driven from the head entry whenever !empty (show-ahead, zero-latency read). Their value when empty is don't-care.
  - Transfer occurs when tx_valid && tx_ready: head increments and one credit is consumed.
  - tx_ready while !tx_valid has no effect.
  - tx_valid does not depend on tx_ready.
  - Once tx_valid is asserted, the offered fields stay stable until the transfer; only a push to a non-full FIFO, a transfer, or reset may change state.
- Credits:
  - Next credits = credits − transfer + credit_ret.
  - A simultaneous transfer and credit_ret leaves credits unchanged.
  - A credit_ret that would exceed CREDIT_INIT is ignored and credits saturate at CREDIT_INIT. This is a protocol error and the bench flags it.
  - With credits == 0 the head is held and tx_valid = 0, even if tx_ready = 1.
- Simultaneous push and transfer:
  - Both occur and count is unchanged.
  - When full, the push is rejected because full is evaluated on the pre-edge count; the pop still occurs.
  - When empty, no transfer occurs because tx_valid = 0; the push occurs and the entry is sent no earlier than the next cycle.
- Ordering: entries leave in exact push order regardless of tag or dest. There is no reordering and no tag match on this side.
- Wrap-around: pointers wrap silently. Full/empty come only from count, never from pointer comparison.
- overflow is cleared only by rst.

Test Plan:
- Reset, then 3 pushes (data 0x0011/0x0022/0x0033, tags 1/2/3, dest 5) with tx_ready=1 → one transfer per cycle in order, credits 8→5, empty=1 afterwards.
- 8 pushes with tx_ready=0 → full=1, count=8; 9th push → overflow=1 and count stays 8; then drain → 8 transfers in push order.
- CREDIT_INIT=2, 4 entries queued, tx_ready held 1 → 2 transfers, then tx_valid=0 with empty=0; credit_ret pulse → exactly one more transfer the next cycle.
- Full FIFO, wen and a transfer in the same cycle → pushed entry dropped, count=7, overflow=1; the next head is the original entry 2.
- Push/pop streaming of 20 entries with random tx_ready and credit_ret → entries pass wrap-around in order, count never exceeds 8, credits never exceed 8.
- rst asserted with count=5 and credits=3 → next cycle count=0, credits=8, tx_valid=0, overflow=0.
